c2h_stream_ctrl: RTL and testbench

//  Parametrised successor of the fixed 128-bit result feedback path. Drains the result FIFO (standard,
//  non-FWFT, 1-cycle read latency) into the XDMA C2H AXI-Stream port once the filter asserts

---
 rtl/c2h_stream_ctrl.sv | 187 ++++++++++++++++++
 tb/tb_c2h_stream_ctrl.sv | 346 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/c2h_stream_ctrl.sv
// Result-FIFO to XDMA C2H AXI-Stream drainer with partial final-beat tkeep,
// a 2-entry output skid and an irq req/ack completion handshake.
module c2h_stream_ctrl #(
   parameter int TCQ        = 1,
   parameter int DATA_WIDTH = 128,
   parameter int KEEP_WIDTH = DATA_WIDTH / 8,
   parameter int LEN_WIDTH  = 32,
   parameter int IRQ_WIDTH  = 1
) (
   input  logic                  user_clk,
   input  logic                  user_rst,
   input  logic                  process_done,
   input  logic [LEN_WIDTH-1:0]  data_len,
   input  logic [DATA_WIDTH-1:0] fifo_dout,
   output logic                  fifo_rd_en,
   input  logic                  fifo_empty,
   output logic [DATA_WIDTH-1:0] m_axis_c2h_tdata,
   output logic [KEEP_WIDTH-1:0] m_axis_c2h_tkeep,
   output logic                  m_axis_c2h_tlast,
   output logic                  m_axis_c2h_tvalid,
   input  logic                  m_axis_c2h_tready,
   output logic [IRQ_WIDTH-1:0]  irq_req,
   input  logic [IRQ_WIDTH-1:0]  irq_ack,
   output logic                  busy,
   output logic                  done_dropped
);

   localparam int KW_LOG2 = $clog2(KEEP_WIDTH);
   localparam int CW      = LEN_WIDTH - KW_LOG2 + 1;
   localparam logic [CW-1:0]         CNT_ONE   = {{(CW-1){1'b0}}, 1'b1};
   localparam logic [KEEP_WIDTH-1:0] KEEP_ONES = '1;

   typedef enum logic [1:0] {
      S_IDLE,
      S_STREAM,
      S_IRQ
   } state_e;

   state_e                state_q, state_d;
   logic [KW_LOG2-1:0]    rem_q, rem_d;
   logic [CW-1:0]         rd_left_q, rd_left_d;
   logic [CW-1:0]         tx_left_q, tx_left_d;
   logic                  inflight_q, inflight_d;
   logic [1:0]            cnt_q, cnt_d;
   logic [DATA_WIDTH-1:0] head_q, head_d;
   logic [DATA_WIDTH-1:0] tail_q, tail_d;
   logic                  irq_req_q, irq_req_d;
   logic                  done_dropped_q, done_dropped_d;

   logic [KW_LOG2-1:0]    len_rem;
   logic [CW-1:0]         beats;
   logic [1:0]            occ;
   logic                  push;
   logic                  pop;
   logic                  room;

   // TCQ only ever shaped simulation delays; this RTL is zero-delay.
   logic                  unused_ok;
   assign unused_ok = ^{irq_ack, TCQ[0]};

   always_comb begin
      len_rem = data_len[KW_LOG2-1:0];
      beats   = {1'b0, data_len[LEN_WIDTH-1:KW_LOG2]}
              + {{(CW-1){1'b0}}, (len_rem != '0)};
      push    = inflight_q;
      pop     = (cnt_q != 2'd0) && m_axis_c2h_tready;
      occ     = cnt_q + {1'b0, inflight_q};
      // A beat leaving this cycle frees its slot, which keeps 1 beat/cycle.
      room    = (occ < 2'd2) || (pop && (occ == 2'd2));
   end

   always_comb begin
      state_d        = state_q;
      rem_d          = rem_q;
      rd_left_d      = rd_left_q;
      tx_left_d      = tx_left_q;
      head_d         = head_q;
      tail_d         = tail_q;
      cnt_d          = cnt_q;
      irq_req_d      = 1'b0;
      done_dropped_d = process_done && (state_q != S_IDLE);
      fifo_rd_en     = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (process_done) begin
               rem_d = len_rem;
               if (data_len == '0) begin
                  state_d = S_IRQ;
               end else begin
                  rd_left_d = beats;
                  tx_left_d = beats;
                  state_d   = S_STREAM;
               end
            end
         end
         S_STREAM: begin
            fifo_rd_en = !fifo_empty && (rd_left_q != '0) && room;
            if (fifo_rd_en) begin
               rd_left_d = rd_left_q - CNT_ONE;
            end
            if (pop) begin
               tx_left_d = tx_left_q - CNT_ONE;
               if (tx_left_q == CNT_ONE) begin
                  state_d = S_IRQ;
               end
            end
         end
         S_IRQ: begin
            if (irq_req_q && irq_ack[0]) begin
               state_d = S_IDLE;
            end else begin
               irq_req_d = 1'b1;
            end
         end
         default: state_d = S_IDLE;
      endcase

      inflight_d = fifo_rd_en;

      case ({push, pop})
         2'b10: begin
            if (cnt_q == 2'd0) begin
               head_d = fifo_dout;
            end else begin
               tail_d = fifo_dout;
            end
            cnt_d = cnt_q + 2'd1;
         end
         2'b01: begin
            head_d = tail_q;
            cnt_d  = cnt_q - 2'd1;
         end
         2'b11: begin
            if (cnt_q == 2'd1) begin
               head_d = fifo_dout;
            end else begin
               head_d = tail_q;
               tail_d = fifo_dout;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge user_clk or negedge user_rst) begin
      if (!user_rst) begin
         state_q        <= S_IDLE;
         rem_q          <= '0;
         rd_left_q      <= '0;
         tx_left_q      <= '0;
         inflight_q     <= 1'b0;
         cnt_q          <= '0;
         head_q         <= '0;
         tail_q         <= '0;
         irq_req_q      <= 1'b0;
         done_dropped_q <= 1'b0;
      end else begin
         state_q        <= state_d;
         rem_q          <= rem_d;
         rd_left_q      <= rd_left_d;
         tx_left_q      <= tx_left_d;
         inflight_q     <= inflight_d;
         cnt_q          <= cnt_d;
         head_q         <= head_d;
         tail_q         <= tail_d;
         irq_req_q      <= irq_req_d;
         done_dropped_q <= done_dropped_d;
      end
   end

   always_comb begin
      m_axis_c2h_tvalid = (cnt_q != 2'd0);
      m_axis_c2h_tdata  = head_q;
      m_axis_c2h_tlast  = m_axis_c2h_tvalid && (tx_left_q == CNT_ONE);
      m_axis_c2h_tkeep  = '0;
      if (m_axis_c2h_tvalid) begin
         m_axis_c2h_tkeep = (m_axis_c2h_tlast && (rem_q != '0)) ?
                            ~(KEEP_ONES << rem_q) : KEEP_ONES;
      end
      irq_req      = '0;
      irq_req[0]   = irq_req_q;
      busy         = (state_q != S_IDLE);
      done_dropped = done_dropped_q;
   end

endmodule

// File: tb/tb_c2h_stream_ctrl.sv
// Bench for c2h_stream_ctrl: queue-based FIFO model, beat scoreboard built from
// length arithmetic, table-driven transfers, abort-by-reset and random transfers.
module tb_c2h_stream_ctrl;

   localparam int DW = 128;
   localparam int KW = 16;
   localparam int LW = 32;
   localparam int IW = 1;

   typedef struct {
      logic [DW-1:0] data;
      logic [KW-1:0] keep;
      logic          last;
   } beat_t;

   typedef struct {
      int            len;
      bit            stall;
      bit            gap;
      bit            drop;
      int            exp_beats;
      logic [KW-1:0] exp_keep;
   } vec_t;

   logic          user_clk = 1'b0;
   logic          user_rst = 1'b0;
   logic          process_done = 1'b0;
   logic [LW-1:0] data_len = '0;
   logic [DW-1:0] fifo_dout;
   logic          fifo_rd_en;
   logic          fifo_empty;
   logic [DW-1:0] m_axis_c2h_tdata;
   logic [KW-1:0] m_axis_c2h_tkeep;
   logic          m_axis_c2h_tlast;
   logic          m_axis_c2h_tvalid;
   logic          m_axis_c2h_tready = 1'b0;
   logic [IW-1:0] irq_req;
   logic [IW-1:0] irq_ack = '0;
   logic          busy;
   logic          done_dropped;

   int            errors = 0;
   int            checks = 0;
   int            cycle_no = 0;
   beat_t         exp_q[$];
   logic [DW-1:0] fifo_mem[$];
   logic          fifo_empty_r = 1'b1;
   logic          fifo_hold = 1'b0;
   int            rd_pulses = 0;
   int            underflows = 0;
   bit            stall_mode = 1'b0;
   bit            stalled_prev = 1'b0;
   beat_t         prev;
   int            beats_seen = 0;
   logic [KW-1:0] last_keep_seen = '0;
   int            first_valid_cyc = -1;

   c2h_stream_ctrl #(
      .DATA_WIDTH (DW),
      .LEN_WIDTH  (LW),
      .IRQ_WIDTH  (IW)
   ) dut (
      .user_clk          (user_clk),
      .user_rst          (user_rst),
      .process_done      (process_done),
      .data_len          (data_len),
      .fifo_dout         (fifo_dout),
      .fifo_rd_en        (fifo_rd_en),
      .fifo_empty        (fifo_empty),
      .m_axis_c2h_tdata  (m_axis_c2h_tdata),
      .m_axis_c2h_tkeep  (m_axis_c2h_tkeep),
      .m_axis_c2h_tlast  (m_axis_c2h_tlast),
      .m_axis_c2h_tvalid (m_axis_c2h_tvalid),
      .m_axis_c2h_tready (m_axis_c2h_tready),
      .irq_req           (irq_req),
      .irq_ack           (irq_ack),
      .busy              (busy),
      .done_dropped      (done_dropped)
   );

   always #5 user_clk = ~user_clk;

   // Standard (non-FWFT) FIFO: data appears the cycle after the read strobe.
   assign fifo_empty = fifo_empty_r | fifo_hold;

   always @(posedge user_clk or negedge user_rst) begin
      if (!user_rst) begin
         fifo_mem.delete();
         fifo_dout    <= '0;
         fifo_empty_r <= 1'b1;
      end else begin
         if (fifo_rd_en) begin
            rd_pulses++;
            if (fifo_mem.size() == 0) underflows++;
            else fifo_dout <= fifo_mem.pop_front();
         end
         fifo_empty_r <= (fifo_mem.size() == 0);
      end
   end

   task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic fail_now(input string name);
      checks++;
      errors++;
      $display("FAIL %s: got timeout expected completion", name);
   endtask

   function automatic logic [KW-1:0] model_keep(input int len, input int idx);
      logic [KW-1:0] k;
      int nb;
      int r;
      nb = (len + KW - 1) / KW;
      r  = len % KW;
      k  = '1;
      if (idx == nb - 1 && r != 0)
         for (int b = 0; b < KW; b++) k[b] = (b < r);
      return k;
   endfunction

   task automatic load_words(input int len);
      logic [DW-1:0] w;
      beat_t e;
      int nb;
      nb = (len + KW - 1) / KW;
      for (int i = 0; i < nb; i++) begin
         w = {$urandom(), $urandom(), $urandom(), $urandom()};
         fifo_mem.push_back(w);
         e.data = w;
         e.keep = model_keep(len, i);
         e.last = (i == nb - 1);
         exp_q.push_back(e);
      end
   endtask

   // One cycle: drive tready, then score whatever the sink accepts at the next edge.
   task automatic tick();
      beat_t e;
      @(negedge user_clk);
      cycle_no++;
      m_axis_c2h_tready = stall_mode ? 1'($urandom_range(0, 1)) : 1'b1;
      if (stalled_prev) begin
         chk("hold_valid", DW'(m_axis_c2h_tvalid), DW'(1'b1));
         chk("hold_data", m_axis_c2h_tdata, prev.data);
         chk("hold_keep", DW'(m_axis_c2h_tkeep), DW'(prev.keep));
         chk("hold_last", DW'(m_axis_c2h_tlast), DW'(prev.last));
      end
      if (m_axis_c2h_tvalid && first_valid_cyc < 0) first_valid_cyc = cycle_no;
      if (m_axis_c2h_tvalid && m_axis_c2h_tready) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_beat: got data %0h expected no beat", m_axis_c2h_tdata);
         end else begin
            e = exp_q.pop_front();
            chk("beat_data", m_axis_c2h_tdata, e.data);
            chk("beat_keep", DW'(m_axis_c2h_tkeep), DW'(e.keep));
            chk("beat_last", DW'(m_axis_c2h_tlast), DW'(e.last));
            if (m_axis_c2h_tlast) last_keep_seen = m_axis_c2h_tkeep;
            beats_seen++;
         end
      end
      stalled_prev = m_axis_c2h_tvalid && !m_axis_c2h_tready;
      prev.data = m_axis_c2h_tdata;
      prev.keep = m_axis_c2h_tkeep;
      prev.last = m_axis_c2h_tlast;
   endtask

   task automatic transfer(input int len, input bit stall, input bit gap, input bit drop,
                           output int nbeats, output logic [KW-1:0] keep_last);
      int nb;
      int rd0;
      int pd_cyc;
      int guard;
      int hold_cnt;
      int drop_phase;
      bit hold_done;
      nb = (len + KW - 1) / KW;
      load_words(len);
      beats_seen      = 0;
      last_keep_seen  = '0;
      first_valid_cyc = -1;
      tick();
      stall_mode   = stall;
      rd0          = rd_pulses;
      data_len     = LW'(len);
      process_done = 1'b1;
      tick();
      process_done = 1'b0;
      data_len     = $urandom();
      pd_cyc       = cycle_no;
      chk("busy_after_start", DW'(busy), DW'(1'b1));

      guard = 0;
      hold_cnt = 0;
      hold_done = 1'b0;
      drop_phase = 0;
      while (beats_seen < nb && guard < 3000) begin
         tick();
         guard++;
         if (drop) begin
            case (drop_phase)
               0: if (beats_seen >= 1) begin
                     process_done = 1'b1;
                     data_len = LW'(5);
                     drop_phase = 1;
                  end
               1: begin
                     process_done = 1'b0;
                     chk("done_dropped_pulse", DW'(done_dropped), DW'(1'b1));
                     drop_phase = 2;
                  end
               2: begin
                     chk("done_dropped_clear", DW'(done_dropped), DW'(1'b0));
                     drop_phase = 3;
                  end
               default: ;
            endcase
         end
         if (gap) begin
            if (fifo_hold) begin
               hold_cnt++;
               if (hold_cnt >= 3) chk("gap_tvalid_low", DW'(m_axis_c2h_tvalid), DW'(1'b0));
               if (hold_cnt == 5) begin
                  fifo_hold = 1'b0;
                  hold_done = 1'b1;
               end
            end else if (!hold_done && beats_seen >= 2) begin
               fifo_hold = 1'b1;
            end
         end
      end
      if (beats_seen < nb) fail_now("stream_timeout");
      if (nb > 0) chk("first_valid_latency", DW'(first_valid_cyc - pd_cyc), DW'(2));

      guard = 0;
      while (!irq_req[0] && guard < 50) begin
         tick();
         guard++;
      end
      if (!irq_req[0]) fail_now("irq_timeout");
      if (nb == 0) chk("irq_latency_zero_len", DW'(cycle_no - pd_cyc), DW'(1));
      tick();
      tick();
      chk("irq_held_until_ack", DW'(irq_req), DW'(1'b1));
      irq_ack = '1;
      tick();
      irq_ack = '0;
      chk("irq_cleared_after_ack", DW'(irq_req), DW'(1'b0));
      chk("idle_after_ack", DW'(busy), DW'(1'b0));
      chk("rd_pulse_count", DW'(rd_pulses - rd0), DW'(nb));
      chk("beats_outstanding", DW'(exp_q.size()), DW'(0));
      chk("fifo_underflow", DW'(underflows), DW'(0));
      stall_mode = 1'b0;
      nbeats     = beats_seen;
      keep_last  = last_keep_seen;
   endtask

   initial begin
      vec_t          vecs[8];
      int            nbs;
      int            len;
      int            guard;
      logic [KW-1:0] kl;

      vecs[0] = '{64,  1'b0, 1'b0, 1'b0, 4,  16'hFFFF};
      vecs[1] = '{40,  1'b0, 1'b0, 1'b0, 3,  16'h00FF};
      vecs[2] = '{160, 1'b1, 1'b0, 1'b0, 10, 16'hFFFF};
      vecs[3] = '{128, 1'b0, 1'b1, 1'b0, 8,  16'hFFFF};
      vecs[4] = '{0,   1'b0, 1'b0, 1'b0, 0,  16'h0000};
      vecs[5] = '{160, 1'b1, 1'b0, 1'b1, 10, 16'hFFFF};
      vecs[6] = '{1,   1'b0, 1'b0, 1'b0, 1,  16'h0001};
      vecs[7] = '{47,  1'b1, 1'b0, 1'b0, 3,  16'h7FFF};

      user_rst = 1'b0;
      tick();
      tick();
      tick();
      chk("rst_tvalid", DW'(m_axis_c2h_tvalid), DW'(1'b0));
      chk("rst_tdata", m_axis_c2h_tdata, DW'(0));
      chk("rst_tkeep", DW'(m_axis_c2h_tkeep), DW'(0));
      chk("rst_rd_en", DW'(fifo_rd_en), DW'(1'b0));
      chk("rst_irq", DW'(irq_req), DW'(0));
      chk("rst_busy", DW'(busy), DW'(1'b0));
      user_rst = 1'b1;
      tick();

      for (int v = 0; v < 8; v++) begin
         transfer(vecs[v].len, vecs[v].stall, vecs[v].gap, vecs[v].drop, nbs, kl);
         chk("vec_beats", DW'(nbs), DW'(vecs[v].exp_beats));
         chk("vec_last_keep", DW'(kl), DW'(vecs[v].exp_keep));
      end

      // Abort an 8-beat transfer with reset while beat 3 is on the bus.
      load_words(128);
      beats_seen = 0;
      tick();
      data_len     = LW'(128);
      process_done = 1'b1;
      tick();
      process_done = 1'b0;
      guard = 0;
      while (beats_seen < 2 && guard < 100) begin
         tick();
         guard++;
      end
      if (beats_seen < 2) fail_now("pre_abort_timeout");
      #3 user_rst = 1'b0;
      #1;
      chk("abort_tvalid", DW'(m_axis_c2h_tvalid), DW'(1'b0));
      chk("abort_tdata", m_axis_c2h_tdata, DW'(0));
      chk("abort_tkeep", DW'(m_axis_c2h_tkeep), DW'(0));
      chk("abort_tlast", DW'(m_axis_c2h_tlast), DW'(1'b0));
      chk("abort_rd_en", DW'(fifo_rd_en), DW'(1'b0));
      chk("abort_irq", DW'(irq_req), DW'(0));
      chk("abort_busy", DW'(busy), DW'(1'b0));
      chk("abort_dropped", DW'(done_dropped), DW'(1'b0));
      exp_q.delete();
      stalled_prev = 1'b0;
      tick();
      tick();
      chk("abort_still_idle", DW'(busy), DW'(1'b0));
      user_rst = 1'b1;
      tick();
      transfer(32, 1'b0, 1'b0, 1'b0, nbs, kl);
      chk("post_abort_beats", DW'(nbs), DW'(2));
      chk("post_abort_keep", DW'(kl), DW'(16'hFFFF));

      for (int k = 0; k < 8; k++) begin
         len = int'($urandom_range(0, 300));
         transfer(len, 1'($urandom_range(0, 1)), 1'b0, 1'b0, nbs, kl);
         chk("rand_beats", DW'(nbs), DW'((len + KW - 1) / KW));
         if (len > 0) chk("rand_last_keep", DW'(kl), DW'(model_keep(len, (len + KW - 1) / KW - 1)));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
